// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble scheduler for the 5-stage pipeline.
// Arbitrates flush, memory wait, multi-cycle divide and load-use hazards.
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_req,
  input  logic                 load_use_ID,
  input  logic                 div_start_EX,
  input  logic                 mem_req_MEM,
  input  logic                 mem_ready,
  output logic                 hold_PC,
  output logic                 hold_IF_ID,
  output logic                 hold_ID_EX,
  output logic                 hold_EX_MEM,
  output logic                 bubble_IF_ID,
  output logic                 bubble_ID_EX,
  output logic                 bubble_EX_MEM,
  output logic                 bubble_MEM_WB,
  output logic                 div_busy,
  output logic                 div_done,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int DW = $clog2(DIV_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    DIV_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 mem_stall;

  assign mem_stall = mem_req_MEM & ~mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_req) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_stall) begin
            state_d = MEM_WAIT;
          end else if (div_start_EX) begin
            state_d = DIV_WAIT;
            cnt_d   = DIV_LOAD;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) state_d = IDLE;
        end
        DIV_WAIT: begin
          if (cnt_q == '0) state_d = IDLE;
          else cnt_d = cnt_q - DW'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hold_PC       = 1'b0;
    hold_IF_ID    = 1'b0;
    hold_ID_EX    = 1'b0;
    hold_EX_MEM   = 1'b0;
    bubble_IF_ID  = 1'b0;
    bubble_ID_EX  = 1'b0;
    bubble_EX_MEM = 1'b0;
    bubble_MEM_WB = 1'b0;
    div_busy      = 1'b0;
    div_done      = 1'b0;
    if (!rst) begin
      div_busy = (state_q == DIV_WAIT);
      if (flush_req) begin
        bubble_IF_ID  = 1'b1;
        bubble_ID_EX  = 1'b1;
        bubble_EX_MEM = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (mem_stall) begin
              {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM} = 4'hf;
              bubble_MEM_WB = 1'b1;
            end else if (div_start_EX) begin
              {hold_PC, hold_IF_ID, hold_ID_EX} = 3'b111;
              bubble_EX_MEM = 1'b1;
            end else if (load_use_ID) begin
              {hold_PC, hold_IF_ID} = 2'b11;
              bubble_ID_EX = 1'b1;
            end
          end
          MEM_WAIT: begin
            if (!mem_ready) begin
              {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM} = 4'hf;
              bubble_MEM_WB = 1'b1;
            end
          end
          DIV_WAIT: begin
            if (cnt_q != '0) begin
              {hold_PC, hold_IF_ID, hold_ID_EX} = 3'b111;
              bubble_EX_MEM = 1'b1;
            end else begin
              div_done = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Counter wraps naturally at 2^CNT_WIDTH; flush leaves it alone.
  assign stall_d      = hold_PC ? stall_q + CNT_WIDTH'(1) : stall_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-output queue.
// DIV_CYCLES=4, CNT_WIDTH=4 so the stall counter wrap is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int DIVC = 4;
  localparam int CW   = 4;

  // {hPC,hIFID,hIDEX,hEXMEM,bIFID,bIDEX,bEXMEM,bMEMWB,busy,done}
  localparam logic [9:0] NONE  = 10'b0000_0000_00;
  localparam logic [9:0] MEMST = 10'b1111_0001_00;
  localparam logic [9:0] DIVST = 10'b1110_0010_00;
  localparam logic [9:0] DIVW  = 10'b1110_0010_10;
  localparam logic [9:0] DONE  = 10'b0000_0000_11;
  localparam logic [9:0] LU    = 10'b1100_0100_00;
  localparam logic [9:0] FL    = 10'b0000_1110_00;
  localparam logic [9:0] FLB   = 10'b0000_1110_10;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  logic clk, rst;
  logic flush_req, load_use_ID, div_start_EX, mem_req_MEM, mem_ready;
  logic hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM;
  logic bubble_IF_ID, bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB;
  logic div_busy, div_done;
  logic [CW-1:0] stall_cycles;

  exp_t       sb[$];
  int         compared;
  int         mismatched;
  logic [CW-1:0] exp_stall;

  pipeline_hazard_ctrl #(
    .DIV_CYCLES(DIVC),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_req    (flush_req),
    .load_use_ID  (load_use_ID),
    .div_start_EX (div_start_EX),
    .mem_req_MEM  (mem_req_MEM),
    .mem_ready    (mem_ready),
    .hold_PC      (hold_PC),
    .hold_IF_ID   (hold_IF_ID),
    .hold_ID_EX   (hold_ID_EX),
    .hold_EX_MEM  (hold_EX_MEM),
    .bubble_IF_ID (bubble_IF_ID),
    .bubble_ID_EX (bubble_ID_EX),
    .bubble_EX_MEM(bubble_EX_MEM),
    .bubble_MEM_WB(bubble_MEM_WB),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs, queue the expectation, check at negedge.
  task automatic cyc(input string tag, input logic r, input logic fl,
                     input logic lu, input logic dv, input logic mq,
                     input logic mr, input logic [9:0] e);
    exp_t item;
    logic [9:0] obs;
    rst          = r;
    flush_req    = fl;
    load_use_ID  = lu;
    div_start_EX = dv;
    mem_req_MEM  = mq;
    mem_ready    = mr;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(negedge clk);
    item = sb.pop_front();
    obs = {hold_PC, hold_IF_ID, hold_ID_EX, hold_EX_MEM,
           bubble_IF_ID, bubble_ID_EX, bubble_EX_MEM, bubble_MEM_WB,
           div_busy, div_done};
    if (r) exp_stall = '0;
    compared++;
    assert (obs === item.exp) else begin
      mismatched++;
      $error("FAIL %s outputs observed=%b expected=%b",
             item.tag, obs, item.exp);
    end
    compared++;
    assert (stall_cycles === exp_stall) else begin
      mismatched++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d",
             item.tag, stall_cycles, exp_stall);
    end
    if (!r && item.exp[9]) exp_stall = exp_stall + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_stall  = '0;
    rst = 1'b1;
    flush_req = 1'b0;
    load_use_ID = 1'b0;
    div_start_EX = 1'b0;
    mem_req_MEM = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset gates outputs even with requests present
    cyc("rst_hold",  1, 1, 1, 1, 1, 0, NONE);
    cyc("idle",      0, 0, 0, 0, 0, 0, NONE);

    // divide, 4 cycles of hold then done
    cyc("div_t0",    0, 0, 0, 1, 0, 0, DIVST);
    cyc("div_t1",    0, 0, 0, 0, 0, 0, DIVW);
    cyc("div_t2",    0, 0, 0, 0, 0, 0, DIVW);
    cyc("div_t3",    0, 0, 0, 0, 0, 0, DIVW);
    cyc("div_done",  0, 0, 0, 0, 0, 0, DONE);
    cyc("div_after", 0, 0, 0, 0, 0, 0, NONE);

    // memory wait of 3 cycles, then zero-wait access
    cyc("mem_w0",    0, 0, 0, 0, 1, 0, MEMST);
    cyc("mem_w1",    0, 0, 0, 0, 1, 0, MEMST);
    cyc("mem_w2",    0, 0, 0, 0, 1, 0, MEMST);
    cyc("mem_rdy",   0, 0, 0, 0, 1, 1, NONE);
    cyc("mem_zw",    0, 0, 0, 0, 1, 1, NONE);

    // mem stall beats divide and load-use; divide follows from IDLE
    cyc("pri_t20",   0, 0, 1, 1, 1, 0, MEMST);
    cyc("pri_t21",   0, 0, 1, 1, 1, 0, MEMST);
    cyc("pri_t22",   0, 0, 0, 1, 1, 1, NONE);
    cyc("pri_t23",   0, 0, 0, 1, 0, 0, DIVST);
    cyc("pri_t24",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("pri_t25",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("pri_t26",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("pri_done",  0, 0, 0, 0, 0, 0, DONE);

    // single-cycle load-use
    cyc("lu_on",     0, 0, 1, 0, 0, 0, LU);
    cyc("lu_off",    0, 0, 0, 0, 0, 0, NONE);

    // flush during divide with div_cnt=2
    cyc("fdiv_t0",   0, 0, 0, 1, 0, 0, DIVST);
    cyc("fdiv_t1",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("fdiv_fl",   0, 1, 0, 0, 0, 0, FLB);
    cyc("fdiv_a1",   0, 0, 0, 0, 0, 0, NONE);
    cyc("fdiv_a2",   0, 0, 0, 0, 0, 0, NONE);
    cyc("fdiv_a3",   0, 0, 0, 0, 0, 0, NONE);

    // 17th stall cycle wraps the 4-bit counter to 1
    cyc("wrap_lu",   0, 0, 1, 0, 0, 0, LU);
    cyc("wrap_chk",  0, 0, 0, 0, 0, 0, NONE);

    // flush overrides a fresh mem stall and an ongoing MEM_WAIT
    cyc("fl_idle",   0, 1, 1, 1, 1, 0, FL);
    cyc("fl_idle2",  0, 0, 0, 0, 0, 0, NONE);
    cyc("fl_mw0",    0, 0, 0, 0, 1, 0, MEMST);
    cyc("fl_mw1",    0, 1, 0, 0, 1, 0, FL);
    cyc("fl_mw2",    0, 0, 0, 0, 0, 0, NONE);

    // reset two cycles into a divide
    cyc("rdiv_t0",   0, 0, 0, 1, 0, 0, DIVST);
    cyc("rdiv_t1",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("rdiv_t2",   0, 0, 0, 0, 0, 0, DIVW);
    cyc("rdiv_rst",  1, 0, 0, 0, 0, 0, NONE);
    cyc("rdiv_a1",   0, 0, 0, 0, 0, 0, NONE);
    cyc("rdiv_a2",   0, 0, 0, 0, 0, 0, NONE);
    cyc("rdiv_a3",   0, 0, 0, 0, 0, 0, NONE);
    cyc("rdiv_a4",   0, 0, 0, 0, 0, 0, NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/bubble scheduler for the 5-stage pipeline.
- Generates the is_hold enables for the PC, IF_ID, ID_EX and EX_MEM pipeline registers, plus bubble (nop-insert) strobes that zero control fields at the next register's inputs.
- Arbitrates three stall sources: the memory wait-state in MEM, the multi-cycle divide in EX, and the load-use hazard in ID. An exception/branch flush overrides all three.
- Also keeps a free-running stall-cycle performance counter.

Parameters:
- DIV_CYCLES, 32, cycles from div_done-less occupancy to result ready; legal range 1..255.
- CNT_WIDTH, 32, width of the stall_cycles performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_req  in  1  flush IF_ID/ID_EX/EX_MEM contents (exception/eret).
- load_use_ID  in  1  ID instruction depends on a load currently in EX.
- div_start_EX  in  1  the instruction in EX is DIV/DIVU.
- mem_req_MEM  in  1  ReadMem_MEM | WriteMem_MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- hold_PC  out  1  freeze PC.
- hold_IF_ID  out  1  is_hold for IF_ID.
- hold_ID_EX  out  1  is_hold for ID_EX.
- hold_EX_MEM  out  1  is_hold for EX_MEM.
- bubble_IF_ID  out  1  insert nop into IF_ID.
- bubble_ID_EX  out  1  insert nop into ID_EX.
- bubble_EX_MEM  out  1  insert nop into EX_MEM.
- bubble_MEM_WB  out  1  insert nop into MEM_WB.
- div_busy  out  1  divider occupying EX.
- div_done  out  1  one-cycle strobe: the divider result is valid this cycle.
- stall_cycles  out  CNT_WIDTH  count of cycles with hold_PC=1.

Behaviour:
- States: IDLE, MEM_WAIT, DIV_WAIT. Registered state plus div_cnt of width clog2(DIV_CYCLES+1). Outputs are combinational from state and inputs.
- Reset (asynchronous): state=IDLE, div_cnt=0, stall_cycles=0. While in reset, all hold and bubble outputs are 0 and div_busy=div_done=0.
- Default, all states: hold_* = 0, bubble_* = 0.
- Priority, evaluated in IDLE: flush_req > memory stall > divide > load-use.
- flush_req=1, any state:
  - bubble_IF_ID, bubble_ID_EX and bubble_EX_MEM = 1; all holds = 0.
  - Next state = IDLE, div_cnt = 0, div_done = 0.
  - Aborts an in-progress wait or divide.
- IDLE, mem_req_MEM=1 and mem_ready=0:
  - hold_PC, hold_IF_ID, hold_ID_EX and hold_EX_MEM = 1; bubble_MEM_WB = 1.
  - Next state = MEM_WAIT.
- IDLE, mem_req_MEM=1 and mem_ready=1: no stall; zero-wait access.
- IDLE, div_start_EX=1 (and no memory stall):
  - hold_PC, hold_IF_ID and hold_ID_EX = 1; bubble_EX_MEM = 1.
  - div_cnt := DIV_CYCLES-1; next state = DIV_WAIT.
- IDLE, load_use_ID=1 (and nothing of higher priority):
  - hold_PC and hold_IF_ID = 1; bubble_ID_EX = 1. State stays IDLE.
  - This is a single-cycle stall unless the load-use condition persists.
- MEM_WAIT:
  - While mem_ready=0: same holds and bubble as the IDLE memory-stall entry.
  - When mem_ready=1: all outputs 0, so EX_MEM and MEM_WB advance at this edge; next state = IDLE.
  - div_start_EX and load_use_ID are ignored in this state and re-evaluated in IDLE.
- DIV_WAIT:
  - div_busy = 1.
  - While div_cnt != 0: hold_PC, hold_IF_ID and hold_ID_EX = 1; bubble_EX_MEM = 1; div_cnt decrements.
  - When div_cnt == 0: div_done = 1 and all holds/bubbles = 0, so EX_MEM captures the quotient/remainder; next state = IDLE.
  - mem_req_MEM is ignored, because MEM holds a bubble after entry.
  - div_start_EX still being high at div_done is ignored, because the instruction leaves EX at that edge.
- Divide timing: div_start_EX sampled in IDLE at cycle t → div_done at cycle t+DIV_CYCLES. EX is occupied for DIV_CYCLES+1 cycles. With DIV_CYCLES=1, div_done occurs at t+1.
- Simultaneous events:
  - mem stall + div_start in IDLE: MEM_WAIT first; the divide starts in the IDLE cycle after mem_ready.
  - mem stall + load_use: the memory stall's holds already cover the load-use hazard; no bubble_ID_EX.
- stall_cycles: increments by 1 on each edge where hold_PC=1. Wraps at 2^CNT_WIDTH to 0. Not cleared by flush.
- Invariant: a register's hold and the bubble into that same register are never both 1.

Test Plan:
- Reset mid-DIV_WAIT: DIV_CYCLES=4, assert rst 2 cycles after div_start → state IDLE immediately, all outputs 0, stall_cycles=0, div_done never pulses.
- Divide: DIV_CYCLES=4, pulse div_start_EX at t=10 → hold_PC=1 at t=10..13; bubble_EX_MEM=1 at t=10..13; div_busy=1 at t=11..14; div_done=1 only at t=14; stall_cycles=4.
- Memory wait: mem_req_MEM=1, mem_ready low for 3 cycles then high → hold_EX_MEM=1 and bubble_MEM_WB=1 for 3 cycles, all 0 in the mem_ready cycle, state back to IDLE; stall_cycles += 3.
- Priority: mem stall and div_start_EX together at t=20, mem_ready at t=22 → MEM_WAIT t=21..22, divide entered from IDLE at t=23, div_done at t=23+DIV_CYCLES.
- Load-use: load_use_ID=1 for exactly 1 cycle → hold_PC=hold_IF_ID=1 and bubble_ID_EX=1 for that cycle only; hold_ID_EX=0.
- Flush: flush_req during DIV_WAIT (div_cnt=2) → bubble_IF_ID/ID_EX/EX_MEM=1 that cycle, next state IDLE, no div_done; and with CNT_WIDTH=4, 17 stall cycles → stall_cycles=1 (wrap).
